banked_unaligned_mem: RTL and testbench

- Dual-requester, byte-banked scratchpad with unaligned multi-byte access. A narrow system-bus port and a wide accelerator interface port share NUM_BANKS byte-wide banks.
- Successor to the single-cycle banked data memory. Adds a parametrised geometry, valid/ready arbitration (fixed or round-robin), registered responses with valid and error flags, and out-of-range protection.

---
 rtl/banked_unaligned_mem.sv | 156 +++++++++++++++
 tb/tb_banked_unaligned_mem.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_unaligned_mem.sv
`default_nettype none
// ============================================================================
// Module   : banked_unaligned_mem
// Purpose  : Byte-banked scratchpad shared by a narrow system port and a wide
//            interface port, with unaligned multi-byte access and range check.
// Revision : 1.0 - initial release
// ============================================================================
module banked_unaligned_mem #(
  parameter int NUM_BANKS = 16,
  parameter int D_WID     = 8,
  parameter int A_WID     = 10,
  parameter int SYS_LANES = 4,
  parameter int ARB_MODE  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sys_req_valid,
  output logic                         sys_req_ready,
  input  logic                         sys_req_we,
  input  logic [SYS_LANES-1:0]         sys_req_mask,
  input  logic [31:0]                  sys_req_addr,
  input  logic [SYS_LANES*D_WID-1:0]   sys_req_wdata,
  output logic                         sys_rsp_valid,
  output logic                         sys_rsp_err,
  output logic [SYS_LANES*D_WID-1:0]   sys_rsp_rdata,
  input  logic                         if_req_valid,
  output logic                         if_req_ready,
  input  logic                         if_req_we,
  input  logic [$clog2(NUM_BANKS):0]   if_req_len,
  input  logic [31:0]                  if_req_addr,
  input  logic [NUM_BANKS*D_WID-1:0]   if_req_wdata,
  output logic                         if_rsp_valid,
  output logic                         if_rsp_err,
  output logic [NUM_BANKS*D_WID-1:0]   if_rsp_rdata
);

  localparam int          c_SW    = $clog2(NUM_BANKS);
  localparam int          c_LW    = c_SW + 1;
  localparam int          c_DW    = NUM_BANKS * D_WID;
  localparam logic [32:0] c_LIMIT = 33'(NUM_BANKS) << A_WID;

  logic                 r_last_if;
  logic                 w_sys_gnt, w_if_gnt, w_acc;
  logic [31:0]          w_addr;
  logic                 w_we;
  logic [c_LW-1:0]      w_len;
  logic [c_DW-1:0]      w_wdata;
  logic [NUM_BANKS-1:0] w_mask;
  logic [32:0]          w_end;
  logic                 w_err, w_wr, w_rd;
  logic [c_SW-1:0]      w_s;
  logic [A_WID-1:0]     w_r;
  logic [NUM_BANKS-1:0] w_lane_en;
  logic [c_DW-1:0]      w_bank_q;
  logic [c_DW-1:0]      w_rot;
  logic [c_SW-1:0]      w_idx;
  logic [NUM_BANKS-1:0] r_lane_en;
  logic [c_SW-1:0]      r_s;
  logic                 r_to_sys;

  // Ready is the grant itself; nothing is accepted while reset is asserted.
  assign w_sys_gnt = rst_n && sys_req_valid && ((ARB_MODE == 0) || !if_req_valid || r_last_if);
  assign w_if_gnt  = rst_n && if_req_valid && !w_sys_gnt;
  assign w_acc     = w_sys_gnt || w_if_gnt;
  assign sys_req_ready = w_sys_gnt;
  assign if_req_ready  = w_if_gnt;

  assign w_addr  = w_sys_gnt ? sys_req_addr : if_req_addr;
  assign w_we    = w_sys_gnt ? sys_req_we : if_req_we;
  assign w_wdata = w_sys_gnt ? c_DW'(sys_req_wdata) : if_req_wdata;
  assign w_mask  = w_sys_gnt ? NUM_BANKS'(sys_req_mask) : '1;

  always_comb begin
    w_len = if_req_len;
    if (w_sys_gnt)
      w_len = c_LW'(SYS_LANES);
    else if (if_req_len > c_LW'(NUM_BANKS))
      w_len = c_LW'(NUM_BANKS);
  end

  assign w_end = {1'b0, w_addr} + 33'(w_len) - 33'd1;
  assign w_err = (w_len != '0) && (w_end >= c_LIMIT);
  assign w_wr  = w_acc && w_we && !w_err;
  assign w_rd  = w_acc && !w_we && !w_err;
  assign w_s   = w_addr[c_SW-1:0];
  assign w_r   = w_addr[c_SW +: A_WID];

  always_comb begin
    w_lane_en = '0;
    for (int k = 0; k < NUM_BANKS; k++)
      w_lane_en[k] = w_rd && (c_LW'(k) < w_len);
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam logic [c_SW-1:0] c_B = c_SW'(b);
    logic [D_WID-1:0] r_mem [2**A_WID];
    logic [D_WID-1:0] r_q;
    logic [c_SW-1:0]  w_k;
    logic [A_WID-1:0] w_row;
    logic             w_act;

    // Banks below the start offset belong to the next row of the access.
    assign w_k   = c_B - w_s;
    assign w_row = w_r + A_WID'(c_B < w_s);
    assign w_act = {1'b0, w_k} < w_len;

    always_ff @(posedge clk) begin
      if (w_wr && w_act && w_mask[w_k])
        r_mem[w_row] <= w_wdata[w_k*D_WID +: D_WID];
      if (w_rd)
        r_q <= r_mem[w_row];
    end

    assign w_bank_q[b*D_WID +: D_WID] = r_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_rsp_valid <= 1'b0;
      sys_rsp_err   <= 1'b0;
      if_rsp_valid  <= 1'b0;
      if_rsp_err    <= 1'b0;
      r_lane_en     <= '0;
      r_s           <= '0;
      r_to_sys      <= 1'b0;
      r_last_if     <= 1'b1;
    end else begin
      sys_rsp_valid <= w_sys_gnt;
      sys_rsp_err   <= w_sys_gnt && w_err;
      if_rsp_valid  <= w_if_gnt;
      if_rsp_err    <= w_if_gnt && w_err;
      r_lane_en     <= w_lane_en;
      r_to_sys      <= w_sys_gnt;
      if (w_rd)
        r_s <= w_s;
      if (w_acc)
        r_last_if <= w_if_gnt;
    end
  end

  // Undo the bank rotation so lane k presents the byte at addr+k.
  always_comb begin
    w_rot = '0;
    w_idx = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      w_idx = r_s + c_SW'(k);
      if (r_lane_en[k])
        w_rot[k*D_WID +: D_WID] = w_bank_q[w_idx*D_WID +: D_WID];
    end
  end

  assign sys_rsp_rdata = r_to_sys ? w_rot[SYS_LANES*D_WID-1:0] : '0;
  assign if_rsp_rdata  = r_to_sys ? '0 : w_rot;

endmodule
`default_nettype wire

// File: tb/tb_banked_unaligned_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_banked_unaligned_mem
// Purpose  : Self-checking bench for banked_unaligned_mem (both arbitration modes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_banked_unaligned_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         sys_req_valid, sys_req_ready, sys_req_we;
  logic [3:0]   sys_req_mask;
  logic [31:0]  sys_req_addr, sys_req_wdata;
  logic         sys_rsp_valid, sys_rsp_err;
  logic [31:0]  sys_rsp_rdata;
  logic         if_req_valid, if_req_ready, if_req_we;
  logic [4:0]   if_req_len;
  logic [31:0]  if_req_addr;
  logic [127:0] if_req_wdata;
  logic         if_rsp_valid, if_rsp_err;
  logic [127:0] if_rsp_rdata;

  logic         b_sys_req_valid, b_sys_req_ready, b_sys_req_we;
  logic [3:0]   b_sys_req_mask;
  logic [31:0]  b_sys_req_addr, b_sys_req_wdata;
  logic         b_sys_rsp_valid, b_sys_rsp_err;
  logic [31:0]  b_sys_rsp_rdata;
  logic         b_if_req_valid, b_if_req_ready, b_if_req_we;
  logic [4:0]   b_if_req_len;
  logic [31:0]  b_if_req_addr;
  logic [127:0] b_if_req_wdata;
  logic         b_if_rsp_valid, b_if_rsp_err;
  logic [127:0] b_if_rsp_rdata;

  banked_unaligned_mem #(.ARB_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .sys_req_valid(sys_req_valid), .sys_req_ready(sys_req_ready), .sys_req_we(sys_req_we),
    .sys_req_mask(sys_req_mask), .sys_req_addr(sys_req_addr), .sys_req_wdata(sys_req_wdata),
    .sys_rsp_valid(sys_rsp_valid), .sys_rsp_err(sys_rsp_err), .sys_rsp_rdata(sys_rsp_rdata),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_we(if_req_we),
    .if_req_len(if_req_len), .if_req_addr(if_req_addr), .if_req_wdata(if_req_wdata),
    .if_rsp_valid(if_rsp_valid), .if_rsp_err(if_rsp_err), .if_rsp_rdata(if_rsp_rdata)
  );

  banked_unaligned_mem #(.ARB_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .sys_req_valid(b_sys_req_valid), .sys_req_ready(b_sys_req_ready), .sys_req_we(b_sys_req_we),
    .sys_req_mask(b_sys_req_mask), .sys_req_addr(b_sys_req_addr), .sys_req_wdata(b_sys_req_wdata),
    .sys_rsp_valid(b_sys_rsp_valid), .sys_rsp_err(b_sys_rsp_err), .sys_rsp_rdata(b_sys_rsp_rdata),
    .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready), .if_req_we(b_if_req_we),
    .if_req_len(b_if_req_len), .if_req_addr(b_if_req_addr), .if_req_wdata(b_if_req_wdata),
    .if_rsp_valid(b_if_rsp_valid), .if_rsp_err(b_if_rsp_err), .if_rsp_rdata(b_if_rsp_rdata)
  );

  typedef struct {
    string        name;
    bit           port_if;
    bit           we;
    logic [31:0]  addr;
    logic [4:0]   len;
    logic [3:0]   mask;
    logic [127:0] wdata;
    bit           exp_err;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t        tab[$];
  logic [7:0]  ref_mem [16384];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [7:0] pat(int a);
    return 8'(a ^ (a >> 8));
  endfunction

  function automatic vec_t mk(string nm, bit p, bit w, logic [31:0] a, logic [4:0] l,
                              logic [3:0] m, logic [127:0] wd, bit e, logic [127:0] rd);
    vec_t v;
    v.name = nm; v.port_if = p; v.we = w; v.addr = a; v.len = l;
    v.mask = m; v.wdata = wd; v.exp_err = e; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    sys_req_valid = 0; if_req_valid = 0;
    b_sys_req_valid = 0; b_if_req_valid = 0;
  endtask

  // One request through the ARB_MODE=0 instance, checked against the byte-array model
  // and, when use_tab is set, against the table's expected response.
  task automatic do_req(input string nm, input bit port_if, input bit we, input logic [31:0] addr,
                        input logic [4:0] len, input logic [3:0] mask, input logic [127:0] wdata,
                        input bit use_tab, input bit t_err, input logic [127:0] t_rdata);
    int           el;
    bit           err, rdy;
    longint       last;
    logic [127:0] exp;
    el   = port_if ? ((len > 5'd16) ? 16 : int'(len)) : 4;
    last = longint'(addr) + longint'(el) - 1;
    err  = (el > 0) && (last >= 16384);
    exp  = '0;
    if (!we && !err)
      for (int k = 0; k < el; k++) exp[k*8 +: 8] = ref_mem[int'(addr) + k];
    @(negedge clk);
    if (port_if) begin
      if_req_valid = 1; if_req_we = we; if_req_len = len; if_req_addr = addr; if_req_wdata = wdata;
    end else begin
      sys_req_valid = 1; sys_req_we = we; sys_req_mask = mask; sys_req_addr = addr;
      sys_req_wdata = wdata[31:0];
    end
    #1;
    rdy = 0;
    for (int c = 0; c < 20; c++) begin
      rdy = port_if ? if_req_ready : sys_req_ready;
      if (rdy) break;
      @(negedge clk); #1;
    end
    if (!rdy) begin
      chk({nm, " ready timeout"}, 128'd0, 128'd1);
      sys_req_valid = 0; if_req_valid = 0;
      return;
    end
    @(posedge clk);
    if (we && !err)
      for (int k = 0; k < el; k++)
        if (port_if || mask[k]) ref_mem[int'(addr) + k] = wdata[k*8 +: 8];
    @(negedge clk);
    sys_req_valid = 0; if_req_valid = 0;
    if (port_if) begin
      chk({nm, " if_rsp_valid"}, 128'(if_rsp_valid), 128'd1);
      chk({nm, " if_rsp_err"},   128'(if_rsp_err),   128'(err));
      chk({nm, " if_rsp_rdata"}, if_rsp_rdata, exp);
      if (use_tab) begin
        chk({nm, " tab err"},   128'(if_rsp_err), 128'(t_err));
        chk({nm, " tab rdata"}, if_rsp_rdata, t_rdata);
      end
    end else begin
      chk({nm, " sys_rsp_valid"}, 128'(sys_rsp_valid), 128'd1);
      chk({nm, " sys_rsp_err"},   128'(sys_rsp_err),   128'(err));
      chk({nm, " sys_rsp_rdata"}, 128'(sys_rsp_rdata), exp);
      if (use_tab) begin
        chk({nm, " tab err"},   128'(sys_rsp_err), 128'(t_err));
        chk({nm, " tab rdata"}, 128'(sys_rsp_rdata), t_rdata);
      end
    end
  endtask

  initial begin
    logic [127:0] wd_rt, wd_40, wd_top, wd_ok, ones;
    logic [31:0]  top4;

    for (int k = 0; k < 16; k++) begin
      wd_rt[k*8 +: 8]  = 8'(k);
      wd_40[k*8 +: 8]  = 8'(8'h80 + k);
      wd_top[k*8 +: 8] = pat(16368 + k);
    end
    for (int k = 0; k < 4; k++) top4[k*8 +: 8] = pat(16380 + k);
    ones  = '1;
    wd_ok = '0;

    tab.push_back(mk("rt_wr",     1, 1, 32'h0D, 5'd16, 4'h0, wd_rt, 0, 128'd0));
    tab.push_back(mk("rt_rd",     1, 0, 32'h0D, 5'd16, 4'h0, 128'd0, 0, wd_rt));
    tab.push_back(mk("sys_rd10",  0, 0, 32'h10, 5'd0, 4'h0, 128'd0, 0, 128'h06050403));
    tab.push_back(mk("sys_mwr",   0, 1, 32'h1E, 5'd0, 4'b1010, 128'hDDCCBBAA, 0, 128'd0));
    tab.push_back(mk("sys_rd1e",  0, 0, 32'h1E, 5'd0, 4'h0, 128'd0, 0, 128'hDD20BB1E));
    tab.push_back(mk("if_rd20",   1, 0, 32'h20, 5'd2, 4'h0, 128'd0, 0, 128'hDD20));
    tab.push_back(mk("len5",      1, 0, 32'h0D, 5'd5, 4'h0, 128'd0, 0, 128'h0403020100));
    tab.push_back(mk("len0_wr",   1, 1, 32'h0D, 5'd0, 4'h0, ones, 0, 128'd0));
    tab.push_back(mk("len0_chk",  1, 0, 32'h0D, 5'd16, 4'h0, 128'd0, 0, wd_rt));
    tab.push_back(mk("len31_wr",  1, 1, 32'h40, 5'd31, 4'h0, wd_40, 0, 128'd0));
    tab.push_back(mk("len31_rd",  1, 0, 32'h40, 5'd31, 4'h0, 128'd0, 0, wd_40));
    tab.push_back(mk("len31_nx",  1, 0, 32'h50, 5'd1, 4'h0, 128'd0, 0, 128'h50));
    tab.push_back(mk("oor_rd",    1, 0, 32'd16376, 5'd16, 4'h0, 128'd0, 1, 128'd0));
    tab.push_back(mk("oor_wr",    1, 1, 32'd16376, 5'd16, 4'h0, ones, 1, 128'd0));
    tab.push_back(mk("top_rd",    1, 0, 32'd16368, 5'd16, 4'h0, 128'd0, 0, wd_top));
    tab.push_back(mk("sys_oor",   0, 0, 32'd16382, 5'd0, 4'h0, 128'd0, 1, 128'd0));
    tab.push_back(mk("sys_top",   0, 0, 32'd16380, 5'd0, 4'h0, 128'd0, 0, 128'(top4)));
    tab.push_back(mk("len0_rd",   1, 0, 32'h0, 5'd0, 4'h0, 128'd0, 0, wd_ok));

    // Reset state, with requests pending to show ready stays low.
    rst_n = 0;
    sys_req_we = 0; sys_req_mask = 0; sys_req_addr = 0; sys_req_wdata = 0;
    if_req_we = 0; if_req_len = 0; if_req_addr = 0; if_req_wdata = 0;
    b_sys_req_we = 0; b_sys_req_mask = 0; b_sys_req_addr = 0; b_sys_req_wdata = 0;
    b_if_req_we = 0; b_if_req_len = 5'd4; b_if_req_addr = 0; b_if_req_wdata = 0;
    sys_req_valid = 1; if_req_valid = 1; b_sys_req_valid = 1; b_if_req_valid = 1;
    #22;
    chk("rst sys_ready", 128'(sys_req_ready), 128'd0);
    chk("rst if_ready",  128'(if_req_ready),  128'd0);
    chk("rst rr sys_ready", 128'(b_sys_req_ready), 128'd0);
    chk("rst rr if_ready",  128'(b_if_req_ready),  128'd0);
    chk("rst rsp_valid", {126'd0, sys_rsp_valid, if_rsp_valid}, 128'd0);
    chk("rst rsp_err",   {126'd0, sys_rsp_err, if_rsp_err}, 128'd0);
    chk("rst sys_rdata", 128'(sys_rsp_rdata), 128'd0);
    chk("rst if_rdata",  if_rsp_rdata, 128'd0);
    idle_inputs();
    @(negedge clk); rst_n = 1;

    // Fill the whole memory with a known pattern.
    for (int i = 0; i < 1024; i++) begin
      logic [127:0] d;
      for (int k = 0; k < 16; k++) d[k*8 +: 8] = pat(i*16 + k);
      do_req("init", 1, 1, 32'(i*16), 5'd16, 4'h0, d, 0, 0, 128'd0);
    end

    foreach (tab[i])
      do_req(tab[i].name, tab[i].port_if, tab[i].we, tab[i].addr, tab[i].len, tab[i].mask,
             tab[i].wdata, 1, tab[i].exp_err, tab[i].exp_rdata);

    // Fixed priority: sys holds the grant while valid.
    @(negedge clk);
    sys_req_valid = 1; sys_req_we = 0; sys_req_addr = 32'h0;
    if_req_valid = 1; if_req_we = 0; if_req_len = 5'd4; if_req_addr = 32'h0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("fix c%0d sys_ready", c), 128'(sys_req_ready), 128'd1);
      chk($sformatf("fix c%0d if_ready", c),  128'(if_req_ready),  128'd0);
      @(negedge clk);
    end
    sys_req_valid = 0;
    #1;
    chk("fix c4 if_ready", 128'(if_req_ready), 128'd1);
    @(negedge clk);
    if_req_valid = 0;
    @(negedge clk);

    // Round-robin: alternates, starting with sys after reset.
    b_sys_req_valid = 1; b_if_req_valid = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rr c%0d sys_ready", c), 128'(b_sys_req_ready), 128'((c % 2) == 0));
      chk($sformatf("rr c%0d if_ready", c),  128'(b_if_req_ready),  128'((c % 2) == 1));
      @(negedge clk);
    end
    b_sys_req_valid = 0; b_if_req_valid = 0;
    @(negedge clk);
    b_sys_req_valid = 1; b_if_req_valid = 1;
    #1;
    chk("rr resume sys_ready", 128'(b_sys_req_ready), 128'd1);
    @(negedge clk);
    #1;
    chk("rr resume if_ready", 128'(b_if_req_ready), 128'd1);
    @(negedge clk);
    b_sys_req_valid = 0; b_if_req_valid = 0;

    // Write accepted on the last edge before reset is kept; its response is dropped.
    @(negedge clk);
    sys_req_valid = 1; sys_req_we = 1; sys_req_mask = 4'hF; sys_req_addr = 32'h100;
    sys_req_wdata = 32'h11223344;
    @(posedge clk);
    for (int k = 0; k < 4; k++) ref_mem[32'h100 + k] = sys_req_wdata[k*8 +: 8];
    #1 rst_n = 0;
    #1;
    chk("rstw sys_rsp_valid", 128'(sys_rsp_valid), 128'd0);
    @(negedge clk);
    sys_req_valid = 0;
    @(negedge clk); rst_n = 1;

    // Read accepted, then reset before the response edge.
    @(negedge clk);
    sys_req_valid = 1; sys_req_we = 0; sys_req_addr = 32'h100;
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rstr sys_rsp_valid", 128'(sys_rsp_valid), 128'd0);
    chk("rstr sys_rsp_rdata", 128'(sys_rsp_rdata), 128'd0);
    @(negedge clk);
    sys_req_valid = 0;
    @(negedge clk); rst_n = 1;
    do_req("post_rst_rd", 0, 0, 32'h100, 5'd0, 4'h0, 128'd0, 1, 0, 128'h11223344);
    do_req("post_rst_rt", 1, 0, 32'h0D, 5'd16, 4'h0, 128'd0, 1, 0, wd_rt);

    // Randomized traffic against the byte-array model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0]  a;
      logic [127:0] d;
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(16340, 16400))
                                      : 32'($urandom_range(0, 16383));
      d = {$urandom, $urandom, $urandom, $urandom};
      do_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
             5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), d, 0, 0, 128'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
